uart_tx_fifo_drain: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_gen.sv | 47 ++++
 rtl/uart_tx_fifo_drain.sv | 186 ++++++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path that drains the TX FIFO.
//   tx_state_t  : transmitter state encoding
//   frame_bits(): number of bit periods in one UART frame
//   IDLE_LVL    : level of the serial line when nothing is being sent
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam logic IDLE_LVL = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      START,
      DATA,
      PARITY,
      STOP
   } tx_state_t;

   // Start bit + data bits + optional parity bit + stop bits.
   function automatic int frame_bits(input int data_width,
                                     input int parity_en,
                                     input int stop_bits);
      return 1 + data_width + parity_en + stop_bits;
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and flags the last cycle of each
// bit period. A clear pulse restarts the period so every new state begins a
// full-length bit.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset
//   clear in   restart the bit period on the next edge
//   tick  out  high during the last cycle of the current bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick
);

   localparam int            CW   = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clear || (cnt_q == LAST)) begin
         cnt_d = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its pre-edge inputs regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain
// Pops bytes from the synchronous TX FIFO (request/response read protocol) and
// serialises each one as: start bit, data LSB first, optional parity, 1 or 2
// stop bits. The serial output is registered and only changes on bit
// boundaries.
// Ports:
//   clk              in   clock, rising edge
//   rst              in   synchronous active-high reset
//   fifo_empty       in   FIFO empty flag, sampled only while idle
//   fifo_read_ready  out  one-cycle read request to the FIFO
//   fifo_read_valid  in   FIFO response, one cycle after the request
//   fifo_data        in   FIFO read data, used only with fifo_read_valid
//   tx               out  serial line, idles high
//   busy             out  high from the read request to the last stop cycle
//   done             out  one-cycle pulse after the last stop cycle
// -----------------------------------------------------------------------------
module uart_tx_fifo_drain
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic                  fifo_read_ready,
   input  logic                  fifo_read_valid,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);

   localparam int            BW        = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
   localparam logic          ODD_BIT   = (PARITY_ODD != 0);

   tx_state_t             state_q, state_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  parity_q, parity_d;
   logic                  tx_q, tx_d;
   logic                  done_q, done_d;
   logic                  tick;
   logic                  clear;

   uart_baud_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk  (clk),
      .rst  (rst),
      .clear(clear),
      .tick (tick)
   );

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      parity_d = parity_q;
      done_d   = 1'b0;
      tx_d     = IDLE_LVL;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) state_d = FETCH;
         end
         FETCH: begin
            state_d = WAIT;
         end
         WAIT: begin
            // No response means the empty flag was stale: give up this frame.
            if (fifo_read_valid) begin
               shift_d  = fifo_data;
               parity_d = (^fifo_data) ^ ODD_BIT;
               state_d  = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (tick) state_d = DATA;
         end
         DATA: begin
            if (tick) begin
               if (bit_q == LAST_DATA) begin
                  state_d = (PARITY_EN != 0) ? PARITY : STOP;
               end else begin
                  bit_d   = bit_q + BW'(1);
                  shift_d = shift_q >> 1;
               end
            end
         end
         PARITY: begin
            if (tick) state_d = STOP;
         end
         STOP: begin
            if (tick) begin
               if (bit_q == LAST_STOP) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Every state entry restarts both the bit period and the bit count.
      clear = (state_d != state_q);
      if (clear) bit_d = '0;

      // tx is computed from the next state so the flop presents the new bit
      // exactly at the boundary, with no combinational path to the pad.
      case (state_d)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_d[0];
         PARITY:  tx_d = parity_q;
         default: tx_d = IDLE_LVL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         bit_q   <= '0;
         tx_q    <= IDLE_LVL;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   // NOTE: the shift register and parity bit are pure datapath; they are always
   // loaded in WAIT before being used, so they carry no reset.
   always_ff @(posedge clk) begin
      shift_q  <= shift_d;
      parity_q <= parity_d;
   end

   assign tx              = tx_q;
   assign done            = done_q;
   assign busy            = (state_q != IDLE);
   assign fifo_read_ready = (state_q == FETCH);

`ifndef SYNTHESIS
   localparam int FRAME_CYCLES = frame_bits(DATA_WIDTH, PARITY_EN, STOP_BITS) * CLKS_PER_BIT;

   logic rd_prev_q;
   int   frame_cyc_q;

   always_ff @(posedge clk) begin
      if (CLKS_PER_BIT < 2) $fatal(1, "CLKS_PER_BIT must be at least 2");
      if ((STOP_BITS != 1) && (STOP_BITS != 2)) $fatal(1, "STOP_BITS must be 1 or 2");
      if (DATA_WIDTH == 0) $fatal(1, "DATA_WIDTH must be non-zero");

      rd_prev_q <= rst ? 1'b0 : fifo_read_ready;
      if (rst || (state_q inside {IDLE, FETCH, WAIT})) begin
         frame_cyc_q <= 0;
      end else begin
         frame_cyc_q <= frame_cyc_q + 1;
      end

      if (!rst) begin
         assert (!(rd_prev_q && fifo_read_ready))
            else $error("fifo_read_ready high on two consecutive cycles");
         if ((state_q == STOP) && (state_d == IDLE)) begin
            assert (frame_cyc_q + 1 == FRAME_CYCLES)
               else $error("frame length %0d, expected %0d", frame_cyc_q + 1, FRAME_CYCLES);
         end
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_drain
// Three transmitters with different framing run side by side, each fed by its
// own FIFO model. A schedule model (position within IDLE/FETCH/WAIT + frame)
// predicts every output on every cycle; directed scenarios add literal pins.
//   dut 0: CLKS_PER_BIT=4, no parity,   1 stop bit
//   dut 1: CLKS_PER_BIT=4, even parity, 2 stop bits
//   dut 2: CLKS_PER_BIT=3, odd parity,  1 stop bit
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_fifo_drain;

   localparam int NDUT        = 3;
   localparam int CPB [NDUT]  = '{4, 4, 3};
   localparam int PE  [NDUT]  = '{0, 1, 1};
   localparam int PO  [NDUT]  = '{0, 0, 1};
   localparam int SB  [NDUT]  = '{1, 2, 1};
   localparam int LOGLEN      = 4096;

   logic       clk = 1'b0;
   logic       rst;
   logic       empty_w [NDUT];
   logic       rdy_w   [NDUT];
   logic       vld_w   [NDUT];
   logic [7:0] dat_w   [NDUT];
   logic       tx_w    [NDUT];
   logic       busy_w  [NDUT];
   logic       done_w  [NDUT];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      uart_tx_fifo_drain #(
         .DATA_WIDTH  (8),
         .CLKS_PER_BIT(CPB[g]),
         .PARITY_EN   (PE[g]),
         .PARITY_ODD  (PO[g]),
         .STOP_BITS   (SB[g])
      ) u_dut (
         .clk            (clk),
         .rst            (rst),
         .fifo_empty     (empty_w[g]),
         .fifo_read_ready(rdy_w[g]),
         .fifo_read_valid(vld_w[g]),
         .fifo_data      (dat_w[g]),
         .tx             (tx_w[g]),
         .busy           (busy_w[g]),
         .done           (done_w[g])
      );
   end

   // Bookkeeping
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   bit   chk_en = 1'b0;
   logic rst_ctl;

   // FIFO models and stimulus controls
   logic [7:0] mem [NDUT][64];
   int         wr_p     [NDUT];
   int         rd_p     [NDUT];
   bit         force_ne [NDUT];
   bit         suppress [NDUT];
   bit         pend     [NDUT];

   // Schedule model: t=0 idle, 1 fetch, 2 wait, 3.. frame cycles
   int          t_m    [NDUT];
   logic [15:0] frm_m  [NDUT];
   logic        done_m [NDUT];

   // Output logs and window counters
   logic tx_log   [NDUT][LOGLEN];
   logic busy_log [NDUT][LOGLEN];
   logic rdy_log  [NDUT][LOGLEN];
   logic done_log [NDUT][LOGLEN];
   int   rdy_cnt  [NDUT];
   int   done_cnt [NDUT];
   int   low_cnt  [NDUT];
   int   busy_cnt [NDUT];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int frame_len(input int i);
      return (1 + 8 + PE[i] + SB[i]) * CPB[i];
   endfunction

   function automatic logic [15:0] build_frame(input int i, input logic [7:0] d);
      logic [15:0] f;
      f    = '1;
      f[0] = 1'b0;
      for (int k = 0; k < 8; k++) f[1+k] = d[k];
      if (PE[i] != 0) f[9] = (^d) ^ (PO[i] != 0);
      return f;
   endfunction

   function automatic logic exp_tx(input int i);
      if (t_m[i] < 3) return 1'b1;
      return frm_m[i][(t_m[i] - 3) / CPB[i]];
   endfunction

   task automatic push(input int i, input logic [7:0] b);
      mem[i][wr_p[i]] = b;
      wr_p[i]++;
   endtask

   task automatic clr_cnt();
      for (int i = 0; i < NDUT; i++) begin
         rdy_cnt[i]  = 0;
         done_cnt[i] = 0;
         low_cnt[i]  = 0;
         busy_cnt[i] = 0;
      end
   endtask

   // One clock cycle: compare this cycle's outputs, drive the inputs sampled at
   // the coming edge, then advance the model across that edge.
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         if (chk_en) begin
            check($sformatf("tx[%0d]@%0d", i, cyc),    32'(tx_w[i]),   32'(exp_tx(i)));
            check($sformatf("ready[%0d]@%0d", i, cyc), 32'(rdy_w[i]),  32'(t_m[i] == 1));
            check($sformatf("busy[%0d]@%0d", i, cyc),  32'(busy_w[i]), 32'(t_m[i] != 0));
            check($sformatf("done[%0d]@%0d", i, cyc),  32'(done_w[i]), 32'(done_m[i]));
         end
         if (cyc < LOGLEN) begin
            tx_log[i][cyc]   = tx_w[i];
            busy_log[i][cyc] = busy_w[i];
            rdy_log[i][cyc]  = rdy_w[i];
            done_log[i][cyc] = done_w[i];
         end
         if (rdy_w[i] === 1'b1)  rdy_cnt[i]++;
         if (done_w[i] === 1'b1) done_cnt[i]++;
         if (tx_w[i] === 1'b0)   low_cnt[i]++;
         if (busy_w[i] === 1'b1) busy_cnt[i]++;
      end

      rst = rst_ctl;
      for (int i = 0; i < NDUT; i++) begin
         vld_w[i] = pend[i];
         if (pend[i]) begin
            dat_w[i] = mem[i][rd_p[i]];
            rd_p[i]++;
         end else begin
            dat_w[i] = 8'hEE;
         end
         pend[i]    = (rdy_w[i] === 1'b1) && !suppress[i];
         empty_w[i] = force_ne[i] ? 1'b0 : (rd_p[i] == wr_p[i]);

         if (rst_ctl) begin
            t_m[i]    = 0;
            done_m[i] = 1'b0;
         end else begin
            done_m[i] = 1'b0;
            if (t_m[i] == 0) begin
               if (!empty_w[i]) t_m[i] = 1;
            end else if (t_m[i] == 1) begin
               t_m[i] = 2;
            end else if (t_m[i] == 2) begin
               if (vld_w[i]) begin
                  frm_m[i] = build_frame(i, dat_w[i]);
                  t_m[i]   = 3;
               end else begin
                  t_m[i] = 0;
               end
            end else if (t_m[i] == 2 + frame_len(i)) begin
               t_m[i]    = 0;
               done_m[i] = 1'b1;
            end else begin
               t_m[i]++;
            end
         end
      end
      cyc++;
   endtask

   initial begin
      int         p;
      int         ones;
      int         busy_lo;
      logic [9:0] seq;
      logic [7:0] got;

      rst     = 1'b1;
      rst_ctl = 1'b1;
      for (int i = 0; i < NDUT; i++) begin
         wr_p[i] = 0; rd_p[i] = 0;
         force_ne[i] = 1'b0; suppress[i] = 1'b0; pend[i] = 1'b0;
         t_m[i] = 0; frm_m[i] = '1; done_m[i] = 1'b0;
         empty_w[i] = 1'b1; vld_w[i] = 1'b0; dat_w[i] = 8'h00;
      end
      clr_cnt();

      // Reset values
      tick();
      tick();
      for (int i = 0; i < NDUT; i++) begin
         check($sformatf("reset tx[%0d]", i),    32'(tx_w[i]),   32'd1);
         check($sformatf("reset ready[%0d]", i), 32'(rdy_w[i]),  32'd0);
         check($sformatf("reset busy[%0d]", i),  32'(busy_w[i]), 32'd0);
         check($sformatf("reset done[%0d]", i),  32'(done_w[i]), 32'd0);
      end
      rst_ctl = 1'b0;
      chk_en  = 1'b1;

      // Empty FIFOs for 200 cycles: line stays idle
      clr_cnt();
      repeat (200) tick();
      for (int i = 0; i < NDUT; i++) begin
         check($sformatf("idle ready count[%0d]", i), 32'(rdy_cnt[i]),  32'd0);
         check($sformatf("idle tx low count[%0d]", i), 32'(low_cnt[i]), 32'd0);
         check($sformatf("idle busy count[%0d]", i),  32'(busy_cnt[i]), 32'd0);
      end

      // 0xA5, no parity, 4 clocks per bit: 40-cycle frame
      p = cyc;
      push(0, 8'hA5);
      clr_cnt();
      repeat (50) tick();
      seq = 10'b1101001010;
      check("A5 latency tx before start", 32'(tx_log[0][p+2]), 32'd1);
      check("A5 latency tx start",        32'(tx_log[0][p+3]), 32'd0);
      for (int k = 0; k < 10; k++) begin
         check($sformatf("A5 bit %0d", k), 32'(tx_log[0][p+5+4*k]), 32'(seq[k]));
      end
      check("A5 ready pulses", 32'(rdy_cnt[0]),  32'd1);
      check("A5 done pulses",  32'(done_cnt[0]), 32'd1);
      check("A5 done cycle",   32'(done_log[0][p+43]), 32'd1);
      check("A5 busy cycles",  32'(busy_cnt[0]), 32'd42);
      check("A5 tx low cycles", 32'(low_cnt[0]), 32'd20);

      // Parity: 0xA5 then 0x07, even (dut 1) and odd (dut 2)
      p = cyc;
      push(1, 8'hA5); push(1, 8'h07);
      push(2, 8'hA5); push(2, 8'h07);
      clr_cnt();
      repeat (130) tick();
      check("even parity A5", 32'(tx_log[1][p+41]), 32'd0);
      check("even parity 07", 32'(tx_log[1][p+92]), 32'd1);
      check("odd parity A5",  32'(tx_log[2][p+31]), 32'd1);
      check("odd parity 07",  32'(tx_log[2][p+67]), 32'd0);
      check("parity done pulses even", 32'(done_cnt[1]), 32'd2);
      check("parity done pulses odd",  32'(done_cnt[2]), 32'd2);

      // 0x00 then 0xFF with two stop bits: 8 stop cycles + 3 idle-line cycles
      p = cyc;
      push(1, 8'h00); push(1, 8'hFF);
      clr_cnt();
      repeat (110) tick();
      ones    = 0;
      busy_lo = 0;
      for (int c = p + 43; c <= p + 53; c++) begin
         if (tx_log[1][c] === 1'b1)   ones++;
         if (busy_log[1][c] === 1'b0) busy_lo++;
      end
      check("00/FF last low before stop", 32'(tx_log[1][p+42]), 32'd0);
      check("00/FF gap high cycles",      32'(ones),            32'd11);
      check("00/FF second start",         32'(tx_log[1][p+54]), 32'd0);
      check("00/FF busy low cycles",      32'(busy_lo),         32'd1);
      check("00/FF busy low at idle",     32'(busy_log[1][p+51]), 32'd0);
      check("00/FF tx low cycles",        32'(low_cnt[1]),      32'd48);

      // Stale empty flag: FETCH without response retries, sends nothing
      p = cyc;
      force_ne[0] = 1'b1;
      suppress[0] = 1'b1;
      clr_cnt();
      repeat (9) tick();
      force_ne[0] = 1'b0;
      suppress[0] = 1'b0;
      repeat (5) tick();
      check("stale first fetch", 32'(rdy_log[0][p+1]), 32'd1);
      check("stale back to idle", 32'(rdy_log[0][p+3]) | 32'(busy_log[0][p+3]), 32'd0);
      check("stale retry fetch", 32'(rdy_log[0][p+4]), 32'd1);
      check("stale ready count", 32'(rdy_cnt[0]), 32'd3);
      check("stale no start bit", 32'(low_cnt[0]), 32'd0);
      check("stale no done", 32'(done_cnt[0]), 32'd0);

      // Reset during data bit 3 of 0x3C; next frame carries 0x5A
      p = cyc;
      push(0, 8'h3C); push(0, 8'h5A);
      repeat (20) tick();
      rst_ctl = 1'b1;
      tick();
      rst_ctl = 1'b0;
      tick();
      check("rst mid-frame tx",   32'(tx_log[0][p+21]),   32'd1);
      check("rst mid-frame busy", 32'(busy_log[0][p+21]), 32'd0);
      check("rst mid-frame done", 32'(done_log[0][p+21]), 32'd0);
      repeat (50) tick();
      check("post-rst tx before start", 32'(tx_log[0][p+23]), 32'd1);
      check("post-rst start bit",       32'(tx_log[0][p+24]), 32'd0);
      for (int b = 0; b < 8; b++) got[b] = tx_log[0][p+30+4*b];
      check("post-rst byte", 32'(got), 32'h5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
